// File: rtl/writeback_stage_pkg.sv
// Shared constants for the write-back stage: datapath width, write-back
// source selector codes and load size/sign codes.
package writeback_stage_pkg;

  localparam int XLEN = 32;

  // Write-back source selector
  localparam logic [1:0] WBSEL_ALU  = 2'b00;
  localparam logic [1:0] WBSEL_LOAD = 2'b01;
  localparam logic [1:0] WBSEL_PC4  = 2'b10;
  localparam logic [1:0] WBSEL_RSV  = 2'b11;

  // Load size/sign codes (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Load data formatter: picks the addressed byte/halfword out of the aligned
// memory word, sign- or zero-extends it, and flags misaligned or illegal loads.
module writeback_stage_load_formatter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);
  import writeback_stage_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane chosen by the full offset, halfword lane by its upper bit
  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = word[{off[1], 4'b0000} +: 16];
  end

  // Extension and alignment/legality check per load type
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data = {{(XLEN-16){half_sel[15]}}, half_sel};
        err  = off[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, half_sel};
        err  = off[0];
      end
      F3_LW: begin
        data = word;
        err  = (off != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result formatting. Sole driver of the
// register block write port; outputs are combinational from the MEM/WB
// register so the register block can bypass them in the same cycle.
module writeback_stage #(
  parameter int XLEN  = writeback_stage_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic             mem_regwr,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wbsel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_word,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic             wb_stall,
  input  logic             wb_flush,
  output logic             regWr,
  output logic [4:0]       ws,
  output logic [XLEN-1:0]  wr_data,
  output logic             wb_valid,
  output logic             load_err,
  output logic [CNT_W-1:0] retired_count
);
  import writeback_stage_pkg::*;

  logic             valid_q,  valid_d;
  logic             regwr_q,  regwr_d;
  logic [4:0]       rd_q,     rd_d;
  logic [1:0]       wbsel_q,  wbsel_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [XLEN-1:0]  alu_q,    alu_d;
  logic [XLEN-1:0]  word_q,   word_d;
  logic [XLEN-1:0]  pc4_q,    pc4_d;
  // Set when the held instruction is in its first WB cycle; gates load_err
  // so a stalled faulting load reports only once.
  logic             first_q,  first_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic [XLEN-1:0]  fmt_data;
  logic             fmt_err;
  logic             err;
  logic             retire;

  writeback_stage_load_formatter #(.XLEN(XLEN)) u_fmt (
    .word   (word_q),
    .off    (alu_q[1:0]),
    .funct3 (funct3_q),
    .data   (fmt_data),
    .err    (fmt_err)
  );

  // Next-state: flush beats stall, stall holds, otherwise capture MEM
  always_comb begin
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    rd_d     = rd_q;
    wbsel_d  = wbsel_q;
    funct3_d = funct3_q;
    alu_d    = alu_q;
    word_d   = word_q;
    pc4_d    = pc4_q;
    first_d  = 1'b0;
    retire   = valid_q & ~wb_stall;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, retire};
    if (wb_flush) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
    end else if (!wb_stall) begin
      valid_d  = mem_valid;
      regwr_d  = mem_regwr;
      rd_d     = mem_rd;
      wbsel_d  = mem_wbsel;
      funct3_d = mem_funct3;
      alu_d    = mem_alu_result;
      word_d   = mem_load_word;
      pc4_d    = mem_pc_plus4;
      first_d  = 1'b1;
    end
  end

  // MEM/WB register and retire counter with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      rd_q     <= '0;
      wbsel_q  <= '0;
      funct3_q <= '0;
      alu_q    <= '0;
      word_q   <= '0;
      pc4_q    <= '0;
      first_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      rd_q     <= rd_d;
      wbsel_q  <= wbsel_d;
      funct3_q <= funct3_d;
      alu_q    <= alu_d;
      word_q   <= word_d;
      pc4_q    <= pc4_d;
      first_q  <= first_d;
      count_q  <= count_d;
    end
  end

  // Write-back value selection, write enable and error pulse
  always_comb begin
    err = valid_q & (wbsel_q == WBSEL_LOAD) & fmt_err;
    case (wbsel_q)
      WBSEL_ALU:  wr_data = alu_q;
      WBSEL_LOAD: wr_data = fmt_data;
      WBSEL_PC4:  wr_data = pc4_q;
      default:    wr_data = '0;
    endcase
    regWr         = valid_q & regwr_q & (rd_q != 5'd0) & ~err & (wbsel_q != WBSEL_RSV);
    ws            = rd_q;
    wb_valid      = valid_q;
    load_err      = err & first_q;
    retired_count = count_q;
  end

endmodule
